// File: rtl/mem_responder.sv
// mem_responder: RAM loader (LOAD) then CPU bus responder with one MMIO register (RUN).
// Build option: RAM_WRITE_THROUGH_EN makes same-edge read-during-write return new data.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_w_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_w_data,
  output logic [DATA_W-1:0] ram_r_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              cpu_rst_n,
  output logic [DATA_W-1:0] mmio_out,
  output logic              ld_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              xfer;
  logic              ovf;
  logic              run;
  logic              is_mmio;
  logic              cpu_wr;
  logic              ram_wr;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] mem [DEPTH];

  assign run      = (state == RUN);
  assign ld_ready = (state == LOAD);
  assign is_mmio  = (ram_addr == MMIO_ADDR);
  assign cpu_wr   = run & ram_w_en;
  assign ram_wr   = cpu_wr & ~is_mmio;

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    ovf       = 1'b0;
    unique case (state)
      LOAD: begin
        if (ld_valid) begin
          xfer = 1'b1;
          if (ld_last) begin
            state_nxt = RUN;
          end else if (ptr == PTR_MAX) begin
            state_nxt = RUN;
            ovf       = 1'b1;
          end
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  always_comb begin
    rd_old  = is_mmio ? mmio_out : mem[ram_addr];
    rd_data = rd_old;
`ifdef RAM_WRITE_THROUGH_EN
    if (ram_w_en) begin
      rd_data = ram_w_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD;
      ptr        <= '0;
      ram_r_data <= '0;
      mmio_out   <= '0;
      cpu_rst_n  <= 1'b0;
      ld_err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_rst_n <= run;
      if (xfer) begin
        ptr <= ptr + 1'b1;
      end
      if (ovf) begin
        ld_err <= 1'b1;
      end
      if (run) begin
        ram_r_data <= rd_data;
      end
      if (cpu_wr && is_mmio) begin
        mmio_out <= ram_w_data;
      end
    end
  end

  // Contents survive rst_n; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (xfer) begin
        mem[ptr] <= ld_data;
      end else if (ram_wr) begin
        mem[ram_addr] <= ram_w_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random + directed stimulus against a behavioural RAM/loader model.
// Build option: RAM_WRITE_THROUGH_EN selects new-data read-during-write expectations.
module tb_mem_responder;

`ifdef RAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_w_en = 1'b0;
  logic [7:0]  ram_addr = '0;
  logic [15:0] ram_w_data = '0;
  logic [15:0] ram_r_data;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [15:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        cpu_rst_n;
  logic [15:0] mmio_out;
  logic        ld_err;

  mem_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .ram_w_en(ram_w_en),
    .ram_addr(ram_addr),
    .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .cpu_rst_n(cpu_rst_n),
    .mmio_out(mmio_out),
    .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a word array, a load cursor and a loading flag.
  logic [15:0] m_mem [256];
  bit          m_ok = 1'b0;
  bit          m_load;
  logic [7:0]  m_ptr;
  logic [15:0] m_rd;
  logic [15:0] m_mmio;
  bit          m_cpu;
  bit          m_err;

  always @(posedge clk) begin
    logic [15:0] old;
    if (!rst_n) begin
      m_ok   = 1'b1;
      m_load = 1'b1;
      m_ptr  = 8'd0;
      m_rd   = 16'd0;
      m_mmio = 16'd0;
      m_cpu  = 1'b0;
      m_err  = 1'b0;
    end else if (m_ok) begin
      if (m_load) begin
        m_cpu = 1'b0;
        if (ld_valid) begin
          m_mem[m_ptr] = ld_data;
          if (!ld_last && m_ptr == 8'd255) m_err = 1'b1;
          if (ld_last || m_ptr == 8'd255) m_load = 1'b0;
          m_ptr = m_ptr + 8'd1;
        end
      end else begin
        m_cpu = 1'b1;
        old = (ram_addr == 8'hFF) ? m_mmio : m_mem[ram_addr];
        m_rd = (WT && ram_w_en) ? ram_w_data : old;
        if (ram_w_en) begin
          if (ram_addr == 8'hFF) m_mmio = ram_w_data;
          else m_mem[ram_addr] = ram_w_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("ld_ready", 32'(ld_ready), 32'(m_load));
      chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
      chk("ld_err", 32'(ld_err), 32'(m_err));
      chk("mmio_out", 32'(mmio_out), 32'(m_mmio));
      if (!$isunknown(m_rd)) chk("ram_r_data", 32'(ram_r_data), 32'(m_rd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    int r;
    r = $urandom_range(0, 9);
    ram_w_en   = 1'($urandom_range(0, 1));
    ram_w_data = 16'($urandom);
    if (r < 2) ram_addr = 8'hFF;
    else if (r < 5) ram_addr = 8'($urandom_range(0, 7));
    else ram_addr = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  logic [15:0] words [3];
  logic [15:0] w0, w255, wa, wb, wc, saved;
  int cnt, guard;
  bit ok;

  initial begin
    words[0] = 16'hC003;
    words[1] = 16'hA101;
    words[2] = 16'hE000;

    do_reset();
    chk("rst_r_data", 32'(ram_r_data), 32'h0);
    chk("rst_mmio", 32'(mmio_out), 32'h0);
    chk("rst_cpu", 32'(cpu_rst_n), 32'h0);
    chk("rst_err", 32'(ld_err), 32'h0);
    chk("rst_ready", 32'(ld_ready), 32'h1);

    // Overflow load: 257 words, no last.
    for (int i = 0; i < 257; i++) begin
      ld_valid = 1'b1;
      ld_last  = 1'b0;
      ld_data  = 16'($urandom);
      if (i == 0) w0 = ld_data;
      if (i == 255) w255 = ld_data;
      rand_bus();
      if (i == 256) ram_w_en = 1'b0;
      cyc();
    end
    ld_valid = 1'b0;
    ram_w_en = 1'b0;
    chk("ovf_err", 32'(ld_err), 32'h1);
    chk("ovf_ready", 32'(ld_ready), 32'h0);
    chk("ovf_cpu", 32'(cpu_rst_n), 32'h1);
    chk("ovf_mem255", 32'(dut.mem[255]), 32'(w255));
    chk("ovf_mem0", 32'(dut.mem[0]), 32'(w0));

    for (int i = 0; i < 300; i++) begin
      rand_bus();
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = 16'($urandom);
      cyc();
    end

    // Three-word load with random valid gaps.
    ram_w_en = 1'b0;
    ld_valid = 1'b0;
    do_reset();
    cnt = 0;
    guard = 0;
    while (cnt < 3 && guard < 60) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = words[cnt];
      ld_last  = (cnt == 2);
      rand_bus();
      ok = ld_valid && ld_ready;
      cyc();
      if (ok) cnt++;
      guard++;
    end
    chk("t1_done", 32'(cnt), 32'd3);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ram_w_en = 1'b0;
    chk("t1_ready", 32'(ld_ready), 32'h0);
    chk("t1_cpu0", 32'(cpu_rst_n), 32'h0);
    chk("t1_err", 32'(ld_err), 32'h0);
    ram_addr = 8'h00;
    cyc();
    chk("t1_cpu1", 32'(cpu_rst_n), 32'h1);
    chk("t1_rd0", 32'(ram_r_data), 32'hC003);
    ram_addr = 8'h01;
    cyc();
    chk("t1_rd1", 32'(ram_r_data), 32'hA101);
    ram_addr = 8'h02;
    cyc();
    chk("t1_rd2", 32'(ram_r_data), 32'hE000);

    // Read latency: value changes only at the edge.
    ram_addr = 8'h01;
    @(negedge clk);
    chk("t2_before", 32'(ram_r_data), 32'hE000);
    cyc();
    chk("t2_after", 32'(ram_r_data), 32'hA101);

    // MMIO write/read.
    saved = dut.mem[255];
    ram_addr   = 8'hFF;
    ram_w_en   = 1'b1;
    ram_w_data = 16'h1234;
    cyc();
    chk("t3_mmio", 32'(mmio_out), 32'h1234);
    ram_w_en = 1'b0;
    cyc();
    chk("t3_rd", 32'(ram_r_data), 32'h1234);
    chk("t3_ram_ff", 32'(dut.mem[255]), 32'(saved));

    // Read-during-write, RAM and MMIO.
    ram_addr   = 8'h05;
    ram_w_en   = 1'b1;
    ram_w_data = 16'hAAAA;
    cyc();
    ram_w_data = 16'h5555;
    cyc();
    chk("t4_rdw_ram", 32'(ram_r_data), WT ? 32'h5555 : 32'hAAAA);
    ram_w_en = 1'b0;
    cyc();
    chk("t4_new_ram", 32'(ram_r_data), 32'h5555);
    ram_addr   = 8'hFF;
    ram_w_en   = 1'b1;
    ram_w_data = 16'h2222;
    cyc();
    chk("t4_rdw_mmio", 32'(ram_r_data), WT ? 32'h2222 : 32'h1234);
    ram_w_en = 1'b0;

    // Reset mid-load.
    do_reset();
    wa = 16'($urandom);
    wb = 16'($urandom);
    wc = 16'($urandom);
    ld_valid = 1'b1;
    ld_data  = wa;
    cyc();
    ld_data = wb;
    cyc();
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    cyc();
    chk("t6_cpu_rst", 32'(cpu_rst_n), 32'h0);
    rst_n    = 1'b1;
    ld_valid = 1'b1;
    ld_last  = 1'b1;
    ld_data  = wc;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("t6_cpu_load", 32'(cpu_rst_n), 32'h0);
    chk("t6_mem0", 32'(dut.mem[0]), 32'(wc));
    chk("t6_mem1", 32'(dut.mem[1]), 32'(wb));
    cyc();
    chk("t6_cpu_run", 32'(cpu_rst_n), 32'h1);

    // Fully random phases with occasional resets.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        rand_bus();
        ld_valid = 1'($urandom_range(0, 1));
        ld_last  = ($urandom_range(0, 15) == 0);
        ld_data  = 16'($urandom);
        if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
        else rst_n = 1'b1;
        cyc();
      end
    end
    rst_n = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
